// File: rtl/recur_stack.sv
// ============================================================================
//  recur_stack : LIFO of packed {i,z,k,l} recursion words for the search engine
//  Optional feature macro: RECUR_STACK_PEAK_EN (adds high-water mark port peak)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module recur_stack #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [31:0]       push_data,
   input  logic              pop,
   output logic [31:0]       pop_data,
   output logic              pop_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
`ifdef RECUR_STACK_PEAK_EN
   ,
   output logic [ADDR_W:0]   peak
`endif
);

   localparam logic [ADDR_W:0] c_DEPTH = DEPTH[ADDR_W:0];

   logic [31:0]       r_mem [DEPTH];
   logic [ADDR_W:0]   r_count;
   logic [31:0]       r_pop_data;
   logic              r_pop_valid;
   logic              r_empty;
   logic              r_full;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_pop_ok;
   logic              w_push_ok;
   logic [ADDR_W:0]   w_sp_m1;
   logic [ADDR_W-1:0] w_top_idx;
   logic [ADDR_W-1:0] w_wr_idx;
   logic [ADDR_W:0]   w_count_next;

   // A pop frees the top slot, so a simultaneous push is legal even when full.
   assign w_pop_ok  = pop && (r_count != '0);
   assign w_push_ok = push && ((r_count != c_DEPTH) || w_pop_ok);
   assign w_sp_m1   = r_count - 1'b1;
   assign w_top_idx = w_sp_m1[ADDR_W-1:0];
   assign w_wr_idx  = w_pop_ok ? w_top_idx : r_count[ADDR_W-1:0];

   always_comb begin
      w_count_next = r_count;
      if (flush)
         w_count_next = '0;
      else if (w_push_ok && !w_pop_ok)
         w_count_next = r_count + 1'b1;
      else if (w_pop_ok && !w_push_ok)
         w_count_next = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && w_push_ok)
         r_mem[w_wr_idx] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_next;
         r_empty     <= (w_count_next == '0);
         r_full      <= (w_count_next == c_DEPTH);
         r_pop_valid <= !flush && w_pop_ok;
         if (!flush && w_pop_ok)
            r_pop_data <= r_mem[w_top_idx];
         if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            if (push && !w_push_ok)
               r_overflow <= 1'b1;
            if (pop && !w_pop_ok)
               r_underflow <= 1'b1;
         end
      end
   end

`ifdef RECUR_STACK_PEAK_EN
   logic [ADDR_W:0] r_peak;

   always_ff @(posedge clk) begin
      if (rst)
         r_peak <= '0;
      else if (w_count_next > r_peak)
         r_peak <= w_count_next;
   end

   assign peak = r_peak;
`endif

   assign count     = r_count;
   assign pop_data  = r_pop_data;
   assign pop_valid = r_pop_valid;
   assign empty     = r_empty;
   assign full      = r_full;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_recur_stack.sv
// ============================================================================
//  tb_recur_stack : directed self-checking bench for recur_stack
//  Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_recur_stack;

   logic        clk = 1'b0;
   logic        rst, flush, push, pop;
   logic [31:0] push_data;
   logic [31:0] pop_data;
   logic        pop_valid, empty, full, overflow, underflow;
   logic [4:0]  count;
`ifdef RECUR_STACK_PEAK_EN
   logic [4:0]  peak;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   recur_stack #(.DEPTH(16), .ADDR_W(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
`ifdef RECUR_STACK_PEAK_EN
      ,
      .peak      (peak)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
      step(); step();
      chk("rst_pop_data",  pop_data,  32'h0);
      chk("rst_pop_valid", {31'b0, pop_valid}, 32'h0);
      chk("rst_count",     {27'b0, count}, 32'h0);
      chk("rst_empty",     {31'b0, empty}, 32'h1);
      chk("rst_full",      {31'b0, full}, 32'h0);
      chk("rst_overflow",  {31'b0, overflow}, 32'h0);
      chk("rst_underflow", {31'b0, underflow}, 32'h0);
`ifdef RECUR_STACK_PEAK_EN
      chk("rst_peak",      {27'b0, peak}, 32'h0);
`endif
      rst = 1'b0;

      // basic LIFO order
      push = 1'b1;
      push_data = 32'h01020304; step();
      push_data = 32'h05060708; step();
      push_data = 32'h0A0B0C0D; step();
      push = 1'b0;
      chk("t1_count", {27'b0, count}, 32'd3);
      chk("t1_empty", {31'b0, empty}, 32'h0);
      chk("t1_valid0", {31'b0, pop_valid}, 32'h0);
      pop = 1'b1;
      step();
      chk("t1_pv1", {31'b0, pop_valid}, 32'h1);
      chk("t1_pd1", pop_data, 32'h0A0B0C0D);
      step();
      chk("t1_pv2", {31'b0, pop_valid}, 32'h1);
      chk("t1_pd2", pop_data, 32'h05060708);
      step();
      chk("t1_pv3", {31'b0, pop_valid}, 32'h1);
      chk("t1_pd3", pop_data, 32'h01020304);
      chk("t1_count_end", {27'b0, count}, 32'd0);
      chk("t1_empty_end", {31'b0, empty}, 32'h1);
      pop = 1'b0;
      step();
      chk("t1_pv_drop", {31'b0, pop_valid}, 32'h0);
      chk("t1_pd_hold", pop_data, 32'h01020304);

      // fill to full, then overflow
      push = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push_data = 32'(i);
         step();
      end
      chk("t2_full", {31'b0, full}, 32'h1);
      chk("t2_count", {27'b0, count}, 32'd16);
      chk("t2_ovf_pre", {31'b0, overflow}, 32'h0);
      push_data = 32'hDEADBEEF; step();
      push = 1'b0;
      chk("t2_ovf", {31'b0, overflow}, 32'h1);
      chk("t2_count_ovf", {27'b0, count}, 32'd16);
      pop = 1'b1; step(); pop = 1'b0;
      chk("t2_pd", pop_data, 32'h0000000F);
      chk("t2_count_pop", {27'b0, count}, 32'd15);
      // replace-top when full
      push = 1'b1; push_data = 32'h10; step();
      chk("t2_full2", {31'b0, full}, 32'h1);
      pop = 1'b1; push_data = 32'h55; step();
      push = 1'b0;
      chk("t2_rt_pd", pop_data, 32'h10);
      chk("t2_rt_count", {27'b0, count}, 32'd16);
      step(); pop = 1'b0;
      chk("t2_rt_next", pop_data, 32'h55);

      // flush, then underflow
      flush = 1'b1; step(); flush = 1'b0;
      chk("t3_flush_count", {27'b0, count}, 32'd0);
      chk("t3_flush_ovf", {31'b0, overflow}, 32'h0);
      chk("t3_flush_pv", {31'b0, pop_valid}, 32'h0);
      pop = 1'b1; step(); pop = 1'b0;
      chk("t3_unf_pv", {31'b0, pop_valid}, 32'h0);
      chk("t3_unf", {31'b0, underflow}, 32'h1);
      chk("t3_unf_pd", pop_data, 32'h55);
      push = 1'b1; push_data = 32'h11; step(); push = 1'b0;
      pop = 1'b1; step(); pop = 1'b0;
      chk("t3_pv", {31'b0, pop_valid}, 32'h1);
      chk("t3_pd", pop_data, 32'h11);

      // simultaneous push/pop with entries present
      push = 1'b1;
      push_data = 32'h99; step();
      push_data = 32'hAA; step();
      pop = 1'b1; push_data = 32'hBB; step();
      push = 1'b0;
      chk("t4_pd", pop_data, 32'hAA);
      chk("t4_pv", {31'b0, pop_valid}, 32'h1);
      chk("t4_count", {27'b0, count}, 32'd2);
      step();
      chk("t4_next", pop_data, 32'hBB);
      step(); pop = 1'b0;
      chk("t4_last", pop_data, 32'h99);
      chk("t4_empty", {31'b0, empty}, 32'h1);

      // simultaneous push/pop on empty: push wins, pop rejected
      flush = 1'b1; step(); flush = 1'b0;
      chk("t4e_unf_clr", {31'b0, underflow}, 32'h0);
      push = 1'b1; pop = 1'b1; push_data = 32'h77; step();
      push = 1'b0;
      chk("t4e_pv", {31'b0, pop_valid}, 32'h0);
      chk("t4e_count", {27'b0, count}, 32'd1);
      chk("t4e_unf", {31'b0, underflow}, 32'h1);
      chk("t4e_pd_hold", pop_data, 32'h99);
      step(); pop = 1'b0;
      chk("t4e_pd", pop_data, 32'h77);

      // flush beats push, peak survives flush
      rst = 1'b1; step(); rst = 1'b0;
      pop = 1'b1; step(); pop = 1'b0;
      push = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         push_data = 32'(i);
         step();
      end
      chk("t5_count", {27'b0, count}, 32'd5);
      chk("t5_unf_set", {31'b0, underflow}, 32'h1);
      flush = 1'b1; push_data = 32'h99; step();
      flush = 1'b0; push = 1'b0;
      chk("t5_count_fl", {27'b0, count}, 32'd0);
      chk("t5_empty_fl", {31'b0, empty}, 32'h1);
      chk("t5_ovf_fl", {31'b0, overflow}, 32'h0);
      chk("t5_unf_fl", {31'b0, underflow}, 32'h0);
`ifdef RECUR_STACK_PEAK_EN
      chk("t5_peak_fl", {27'b0, peak}, 32'd5);
`endif
      pop = 1'b1; step(); pop = 1'b0;
      chk("t5_push_ignored", {31'b0, pop_valid}, 32'h0);

      // reset beats pop
      push = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_data = 32'hA1 + 32'(i);
         step();
      end
      push = 1'b0;
      chk("t6_count_pre", {27'b0, count}, 32'd4);
      rst = 1'b1; pop = 1'b1; step();
      rst = 1'b0; pop = 1'b0;
      chk("t6_pv", {31'b0, pop_valid}, 32'h0);
      chk("t6_count", {27'b0, count}, 32'd0);
      chk("t6_pd", pop_data, 32'h0);
`ifdef RECUR_STACK_PEAK_EN
      chk("t6_peak", {27'b0, peak}, 32'd0);
`endif
      step();
      chk("t6_pv_after", {31'b0, pop_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/recur_stack.md
Name: recur_stack

Overview:
- LIFO of packed recursion-parameter words `{i,z,k,l}` for the inexact-recursion search engine.
- Sits directly upstream of the parameter-fetch stage.
- Branch expansion pushes new candidate tuples; the fetch stage pops one word per request and unpacks it into its 8-bit i/z/k/l outputs.
- Provides full/empty status, occupancy, a flush, and sticky error flags for the controller.

Parameters:
- DEPTH, 16, number of 32-bit entries (power of two, 2..256).
- ADDR_W, 4, log2(DEPTH); count is ADDR_W+1 bits.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of stack contents and flags.
- push  input  1  write push_data on top of stack this cycle.
- push_data  input  32  packed tuple: [31:24]=i, [23:16]=z, [15:8]=k, [7:0]=l.
- pop  input  1  read request from fetch stage (its sequential read enable).
- pop_data  output  32  top word, registered; same packing as push_data.
- pop_valid  output  1  one-cycle pulse, pop_data valid.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- count  output  ADDR_W+1  current occupancy.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.
- peak  output  ADDR_W+1  high-water mark; present only with the optional feature.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high on rst, sampled at the clk rising edge.
  - Outputs at reset: pop_data=0, pop_valid=0, count=0, empty=1, full=0, overflow=0, underflow=0, peak=0.
  - Storage array contents are not reset.
- Storage: reg array DEPTH x 32; stack pointer sp = count; top entry = mem[sp-1].
- Pop:
  - When pop=1 and count>0, the next edge sets pop_data<=mem[sp-1], pop_valid<=1 and count<=count-1.
  - Latency is exactly 1 cycle from pop sample to pop_valid.
  - pop_valid is low in every cycle with no accepted pop.
  - Back-to-back pops are allowed every cycle.
- Push: when push=1 and count<DEPTH, the next edge sets mem[sp]<=push_data and count<=count+1.
- Push and pop together, count>0:
  - pop returns the old top (mem[sp-1]) and push_data overwrites slot sp-1.
  - count is unchanged; pop_valid=1.
- Push and pop together, count==0:
  - Push is accepted (count becomes 1).
  - Pop is rejected: pop_valid=0 and underflow is set. No bypass path.
- Push and pop together, count==DEPTH: both are legal (replace-top). overflow is not set.
- Push when full, no pop: write dropped, count unchanged, overflow<=1 (sticky).
- Pop when empty: pop_valid=0, pop_data holds its previous value, underflow<=1 (sticky).
- pop_data holds its last value between pops.
- Status outputs: empty, full and count are registered and reflect post-edge occupancy.
- Flush:
  - Next edge: count<=0, pop_valid<=0, overflow<=0, underflow<=0. peak is kept.
  - Flush has priority over push and pop in the same cycle; both are ignored and no flags are set.
- Reset priority: rst has priority over flush, push and pop. Reset mid-burst discards all pending data; no pop_valid follows a pop sampled together with rst.
- Width rules:
  - count never wraps (saturating checks above).
  - sp arithmetic uses ADDR_W+1 bits; mem index uses the low ADDR_W bits.

Optional Feature:
- Macro: RECUR_STACK_PEAK_EN.
- When defined:
  - Port peak exists.
  - peak<=max(peak, next count) every cycle.
  - Cleared only by rst; flush does not clear it.
- When undefined:
  - No peak port and no peak register.
  - All other behaviour is identical.

Test Plan:
- Reset, then push 0x01020304, 0x05060708, 0x0A0B0C0D on consecutive cycles -> count=3, empty=0. Pop x3 -> pop_valid pulses on 3 consecutive cycles, the cycle after each pop, with data 0x0A0B0C0D, 0x05060708, 0x01020304. Then count=0, empty=1.
- Push 16 words 0x00000000..0x0000000F, then push 0xDEADBEEF -> full=1, count=16, overflow=1. Next pop returns 0x0000000F.
- Pop on empty stack -> pop_valid=0, underflow=1, pop_data unchanged. Following push 0x11 then pop -> pop_valid=1, data 0x00000011.
- With count=2 (top 0xAA), assert push 0xBB and pop together -> pop_data=0xAA, count stays 2. Next pop returns 0xBB.
- Fill 5 entries with overflow/underflow set, assert flush together with push -> count=0, flags=0, push ignored. With RECUR_STACK_PEAK_EN: peak=5 after flush, 0 after rst.
- Pop asserted in the same cycle as rst with count=4 -> pop_valid=0 next cycle, count=0, pop_data=0.
